// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller datapath: control-word layout,
// counter control encodings, button codes and the bit order of the buttons byte.
package nes_pkg;

    localparam int CW_W        = 10;
    localparam int CW_DELAY_LSB = 8;
    localparam int CW_CODE_LSB  = 4;
    localparam int CW_LATCH     = 3;
    localparam int CW_CLK       = 2;
    localparam int CW_PULSE_LSB = 0;

    typedef enum logic [1:0] {
        CTR_HOLD = 2'b00,
        CTR_INC  = 2'b01,
        CTR_RSVD = 2'b10,
        CTR_CLR  = 2'b11
    } ctr_ctrl_e;

    // Codes follow the controller's shift order: A comes out first, Right last
    typedef enum logic [3:0] {
        BTN_NONE   = 4'd0,
        BTN_A      = 4'd1,
        BTN_B      = 4'd2,
        BTN_SELECT = 4'd3,
        BTN_START  = 4'd4,
        BTN_UP     = 4'd5,
        BTN_DOWN   = 4'd6,
        BTN_LEFT   = 4'd7,
        BTN_RIGHT  = 4'd8
    } btn_code_e;

    localparam int BIT_A      = 0;
    localparam int BIT_B      = 1;
    localparam int BIT_SELECT = 2;
    localparam int BIT_START  = 3;
    localparam int BIT_UP     = 4;
    localparam int BIT_DOWN   = 5;
    localparam int BIT_LEFT   = 6;
    localparam int BIT_RIGHT  = 7;

    function automatic logic is_capture_code(input logic [3:0] code);
        return (code >= BTN_A) && (code <= BTN_RIGHT);
    endfunction

    function automatic logic [2:0] code_to_bit(input logic [3:0] code);
        return 3'(code - 4'd1);
    endfunction

endpackage

// File: rtl/nes_controller_datapath_if.sv
// Bundle between the NES FSM / controller pins and the datapath; the counts are
// exported so the timing state can be observed alongside the status ticks.
interface nes_controller_datapath_if #(
  parameter int DELAY_W = 19,
  parameter int PULSE_W = 8
);
  logic [9:0]         cw_NESController;
  logic [1:0]         sw_NESController;
  logic               nes_latch;
  logic               nes_clk;
  logic               nes_data;
  logic [7:0]         buttons;
  logic               buttons_valid;
  logic [DELAY_W-1:0] delay_count;
  logic [PULSE_W-1:0] pulse_count;

  modport master (
    output cw_NESController, nes_data,
    input  sw_NESController, nes_latch, nes_clk, buttons, buttons_valid,
    input  delay_count, pulse_count
  );

  modport slave (
    input  cw_NESController, nes_data,
    output sw_NESController, nes_latch, nes_clk, buttons, buttons_valid,
    output delay_count, pulse_count
  );
endinterface

// File: rtl/nes_mod_counter.sv
// Modulo-MAX counter driven by a 2-bit hold/inc/clear control; tick is combinational
// and flags the increment that wraps the count back to zero.
module nes_mod_counter
  import nes_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   ctrl,
  output logic [W-1:0] count,
  output logic         tick
);
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      case (ctrl)
        CTR_INC: count <= (count == LAST) ? '0 : count + 1'b1;
        CTR_CLR: count <= '0;
        default: count <= count;
      endcase
    end
  end

  assign tick = (ctrl == CTR_INC) && (count == LAST);
endmodule

// File: rtl/nes_controller_datapath.sv
// Datapath for the NES controller reader: poll/phase counters, pin drivers and button capture.
// Define NES_DATA_SYNC_EN to pass nes_data through a two-flop synchronizer before sampling.
module nes_controller_datapath
  import nes_pkg::*;
#(
  parameter int DELAY_MAX = 416667,
  parameter int PULSE_MAX = 150
) (
  input  logic                     clk,
  input  logic                     reset_n,
  nes_controller_datapath_if.slave bus
);
  localparam int DW = (DELAY_MAX > 1) ? $clog2(DELAY_MAX) : 1;
  localparam int PW = (PULSE_MAX > 1) ? $clog2(PULSE_MAX) : 1;

  logic [1:0]    delay_ctrl;
  logic [1:0]    pulse_ctrl;
  logic [3:0]    code;
  logic [DW-1:0] delay_count;
  logic [PW-1:0] pulse_count;
  logic          delay_tick;
  logic          pulse_tick;
  logic          data_s;
  logic          capture;
  logic          pulse_clr;
  logic [7:0]    shadow;
  logic [7:0]    buttons_q;
  logic          valid_q;
  logic          latch_q;
  logic          clk_q;

  assign delay_ctrl = bus.cw_NESController[CW_DELAY_LSB +: 2];
  assign pulse_ctrl = bus.cw_NESController[CW_PULSE_LSB +: 2];
  assign code       = bus.cw_NESController[CW_CODE_LSB +: 4];

  nes_mod_counter #(.MAX(DELAY_MAX), .W(DW)) u_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .ctrl    (delay_ctrl),
    .count   (delay_count),
    .tick    (delay_tick)
  );

  nes_mod_counter #(.MAX(PULSE_MAX), .W(PW)) u_pulse (
    .clk     (clk),
    .reset_n (reset_n),
    .ctrl    (pulse_ctrl),
    .count   (pulse_count),
    .tick    (pulse_tick)
  );

`ifdef NES_DATA_SYNC_EN
  // Reset to 1 so an idle line reads as "not pressed" while the chain fills
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], bus.nes_data};
  end
  assign data_s = sync_q[1];
`else
  assign data_s = bus.nes_data;
`endif

  assign capture   = pulse_tick && is_capture_code(code);
  assign pulse_clr = (pulse_ctrl == CTR_CLR);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow    <= '0;
      buttons_q <= '0;
      valid_q   <= 1'b0;
      latch_q   <= 1'b0;
      clk_q     <= 1'b0;
    end else begin
      latch_q <= bus.cw_NESController[CW_LATCH];
      clk_q   <= bus.cw_NESController[CW_CLK];
      valid_q <= 1'b0;
      // A clear discards any partial frame, even on the Right slot
      if (pulse_clr) begin
        shadow <= '0;
      end else if (capture) begin
        shadow[code_to_bit(code)] <= ~data_s;
        if (code == BTN_RIGHT) begin
          buttons_q <= {~data_s, shadow[BIT_LEFT:BIT_A]};
          valid_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.sw_NESController = {delay_tick, pulse_tick};
  assign bus.nes_latch        = latch_q;
  assign bus.nes_clk          = clk_q;
  assign bus.buttons          = buttons_q;
  assign bus.buttons_valid    = valid_q;
  assign bus.delay_count      = delay_count;
  assign bus.pulse_count      = pulse_count;
endmodule

// File: tb/tb_nes_controller_datapath.sv
// Directed bench for nes_controller_datapath (DELAY_MAX=10, PULSE_MAX=4): vector table
// for counters and pin drivers, plus hand-written frames acting as the NES FSM.
module tb_nes_controller_datapath;
  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  nes_controller_datapath_if #(.DELAY_W(4), .PULSE_W(2)) bus ();

  nes_controller_datapath #(.DELAY_MAX(10), .PULSE_MAX(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [9:0] cw;
    logic [1:0] exp_sw;
    logic [1:0] exp_lc;
    int         exp_dc;
    int         exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [9:0] cw, input logic [1:0] sw,
                              input logic [1:0] lc, input int dc, input int pc);
    vec_t v;
    v.cw = cw; v.exp_sw = sw; v.exp_lc = lc; v.exp_dc = dc; v.exp_pc = pc;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] cw, input logic d);
    bus.cw_NESController = cw;
    bus.nes_data         = d;
    @(posedge clk);
    #1;
  endtask

  // One NES frame: clear, latch phase, then codes 1..8 with four pulse cycles each
  task automatic run_frame(input logic [7:0] pressed, input int abort_after,
                           input int reset_at, output int vcnt);
    vcnt = 0;
    drive(10'h003, 1'b1);
    for (int p = 0; p < 4; p++) drive(10'b00_0000_1_0_01, 1'b1);
    for (int code = 1; code <= 8; code++) begin
      for (int ph = 0; ph < 4; ph++) begin
        if (reset_at == code && ph == 2) reset_n = 1'b0;
        drive({2'b00, 4'(code), 1'b0, (ph == 1 || ph == 2), 2'b01}, ~pressed[code-1]);
        vcnt += int'(bus.buttons_valid);
        if (reset_at == code && ph == 2) return;
      end
      if (abort_after == code) begin
        drive({2'b00, 4'(code + 1), 1'b0, 1'b0, 2'b11}, 1'b1);
        vcnt += int'(bus.buttons_valid);
        drive(10'h000, 1'b1);
        vcnt += int'(bus.buttons_valid);
        return;
      end
    end
    for (int p = 0; p < 2; p++) begin
      drive(10'h000, 1'b1);
      vcnt += int'(bus.buttons_valid);
    end
  endtask

  initial begin
    int vcnt;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.cw_NESController = 10'h000;
    bus.nes_data         = 1'b1;

    // Delay counter: wrap, hold, reserved hold, clear
    for (int i = 0; i < 10; i++) add(10'h100, (i == 9) ? 2'b10 : 2'b00, 2'b00, (i + 1) % 10, 0);
    for (int i = 0; i < 4; i++)  add(10'h100, 2'b00, 2'b00, i + 1, 0);
    add(10'h000, 2'b00, 2'b00, 4, 0);
    add(10'h200, 2'b00, 2'b00, 4, 0);
    for (int i = 0; i < 6; i++)  add(10'h100, (i == 5) ? 2'b10 : 2'b00, 2'b00, (i + 5) % 10, 0);
    for (int i = 0; i < 3; i++)  add(10'h100, 2'b00, 2'b00, i + 1, 0);
    add(10'h300, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 10; i++) add(10'h100, (i == 9) ? 2'b10 : 2'b00, 2'b00, (i + 1) % 10, 0);
    // Pulse counter: tick every 4th cycle, clear at count 2 gives no tick
    for (int i = 0; i < 8; i++)  add(10'h001, (i % 4 == 3) ? 2'b01 : 2'b00, 2'b00, 0, (i + 1) % 4);
    add(10'h001, 2'b00, 2'b00, 0, 1);
    add(10'h001, 2'b00, 2'b00, 0, 2);
    add(10'h003, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++)  add(10'h001, (i == 3) ? 2'b01 : 2'b00, 2'b00, 0, (i + 1) % 4);
    // Latch and clock pins follow cw one edge later
    add(10'h00C, 2'b00, 2'b11, 0, 0);
    add(10'h008, 2'b00, 2'b10, 0, 0);
    add(10'h004, 2'b00, 2'b01, 0, 0);
    add(10'h000, 2'b00, 2'b00, 0, 0);

    drive(10'h000, 1'b1);
    drive(10'h00C, 1'b1);
    check("reset_latch", int'(bus.nes_latch), 0);
    check("reset_clk", int'(bus.nes_clk), 0);
    check("reset_buttons", int'(bus.buttons), 0);
    check("reset_valid", int'(bus.buttons_valid), 0);
    check("reset_dcount", int'(bus.delay_count), 0);
    check("reset_pcount", int'(bus.pulse_count), 0);
    bus.cw_NESController = 10'h000;
    reset_n = 1'b1;
    #1;
    check("reset_sw", int'(bus.sw_NESController), 0);

    foreach (vecs[i]) begin
      bus.cw_NESController = vecs[i].cw;
      #1;
      check($sformatf("vec%0d_sw", i), int'(bus.sw_NESController), int'(vecs[i].exp_sw));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_latch_clk", i), int'({bus.nes_latch, bus.nes_clk}), int'(vecs[i].exp_lc));
      check($sformatf("vec%0d_dcount", i), int'(bus.delay_count), vecs[i].exp_dc);
      check($sformatf("vec%0d_pcount", i), int'(bus.pulse_count), vecs[i].exp_pc);
    end

    run_frame(8'h81, 0, 0, vcnt);
    check("frame_a_right_buttons", int'(bus.buttons), 'h81);
    check("frame_a_right_valid", vcnt, 1);

    run_frame(8'hFF, 5, 0, vcnt);
    check("abort_after_up_buttons", int'(bus.buttons), 'h81);
    check("abort_after_up_valid", vcnt, 0);

    run_frame(8'hFF, 7, 0, vcnt);
    check("clear_on_right_buttons", int'(bus.buttons), 'h81);
    check("clear_on_right_valid", vcnt, 0);

    run_frame(8'h00, 0, 0, vcnt);
    check("released_buttons", int'(bus.buttons), 'h00);
    check("released_valid", vcnt, 1);

    run_frame(8'h5A, 0, 0, vcnt);
    check("pattern_5a_buttons", int'(bus.buttons), 'h5A);
    check("pattern_5a_valid", vcnt, 1);

    run_frame(8'hFF, 0, 6, vcnt);
    check("midreset_buttons", int'(bus.buttons), 0);
    check("midreset_valid", int'(bus.buttons_valid), 0);
    check("midreset_latch", int'(bus.nes_latch), 0);
    check("midreset_clk", int'(bus.nes_clk), 0);
    check("midreset_pcount", int'(bus.pulse_count), 0);
    bus.cw_NESController = 10'h000;
    #1;
    check("midreset_sw", int'(bus.sw_NESController), 0);
    reset_n = 1'b1;

    run_frame(8'h24, 0, 0, vcnt);
    check("after_reset_buttons", int'(bus.buttons), 'h24);
    check("after_reset_valid", vcnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
